// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Front end of the pipelined datapath. Owns the program counter, presents
//   it as a word-aligned byte address to a combinational instruction memory,
//   and captures the returned word into the IF/ID pipeline register. It also
//   handles stall, flush, branch/jump redirect and halt detection.
//
// Optional feature (compile-time macro):
//   FETCH_BOUND_CHECK_EN
//     When defined, fetches from PC >= MEM_WORDS*4 load a bubble into IF/ID
//     and set the sticky FetchFault flag. When undefined, there is no range
//     check and FetchFault is tied to 0.
//
// Ports:
//   Clk               in   1   rising-edge clock
//   Rst               in   1   asynchronous active-low reset
//   Stall             in   1   hold PC and IF/ID
//   Flush             in   1   next IF/ID load becomes a bubble
//   Branch            in   1   redirect to BranchTarget
//   BranchTarget      in  32   branch destination byte address
//   Jump              in   1   redirect to JumpTarget (beats Branch)
//   JumpTarget        in  32   jump destination byte address
//   Address           out 32   byte address to instruction memory (= PC)
//   Instruction       in  32   word returned combinationally by memory
//   PC                out 32   current program counter
//   IF_ID_Instruction out 32   registered fetched instruction
//   IF_ID_PCPlus4     out 32   registered PC+4 of that instruction
//   IF_ID_Valid       out  1   IF/ID holds a real instruction
//   Halted            out  1   fetch halted (leave only through reset)
//   FetchFault        out  1   sticky out-of-range fetch flag
//   DbgState          out  2   FSM state: 0=BOOT, 1=RUN, 2=HALTED
//
// Handshake: there is no valid/ready pair on the memory side. Address is
// valid every cycle and Instruction must be valid within the same cycle;
// IF_ID_Valid qualifies the IF/ID register contents for the decode stage.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 174,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Branch,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        Halted,
  output logic        FetchFault,
  output logic [1:0]  DbgState
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pcplus4;
  logic        r_if_valid;
  logic        r_halted;

  logic [31:0] w_pc_plus4;
  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_oob;
  logic        w_load;
  logic        w_halt_hit;

  // MEM_WORDS must describe a real memory.
  if (MEM_WORDS < 1) begin : g_bad_mem_words
    $error("instr_fetch_unit: MEM_WORDS must be at least 1");
  end

  // 32-bit modulo increment: 32'hFFFF_FFFC wraps to 0.
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_redirect = Jump | Branch;
  // Jump beats Branch; misaligned targets are silently word-aligned.
  assign w_target   = Jump ? {JumpTarget[31:2], 2'b00}
                           : {BranchTarget[31:2], 2'b00};

`ifdef FETCH_BOUND_CHECK_EN
  localparam logic [31:0] BOUND_BYTES = 32'(MEM_WORDS) * 32'd4;
  logic r_fault;

  assign w_oob      = (r_pc >= BOUND_BYTES);
  assign FetchFault = r_fault;

  // Sticky until reset; set at any non-stalled RUN edge that fetched out of range.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_fault <= 1'b0;
    end else if ((r_state == ST_RUN) && w_oob && !Stall) begin
      r_fault <= 1'b1;
    end
  end
`else
  assign w_oob      = 1'b0;
  assign FetchFault = 1'b0;
`endif

  // A real instruction enters IF/ID only when nothing kills or holds it.
  assign w_load     = !w_redirect && !Flush && !Stall;
  assign w_halt_hit = w_load && !w_oob && (Instruction == HALT_WORD);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_PC;
      r_if_instr   <= 32'd0;
      r_if_pcplus4 <= 32'd0;
      r_if_valid   <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          // PC held; IF/ID gets one bubble while memory settles on RESET_PC.
          r_if_instr   <= 32'd0;
          r_if_pcplus4 <= 32'd0;
          r_if_valid   <= 1'b0;
          r_state      <= ST_RUN;
        end

        ST_RUN: begin
          // PC update, first matching rule wins.
          if (w_redirect) begin
            r_pc <= w_target;
          end else if (Stall || w_halt_hit) begin
            r_pc <= r_pc;
          end else begin
            r_pc <= w_pc_plus4;
          end

          // IF/ID update: redirect/flush kill the wrong-path fetch.
          if (w_redirect || Flush) begin
            r_if_instr   <= 32'd0;
            r_if_pcplus4 <= 32'd0;
            r_if_valid   <= 1'b0;
          end else if (Stall) begin
            r_if_instr   <= r_if_instr;
            r_if_pcplus4 <= r_if_pcplus4;
            r_if_valid   <= r_if_valid;
          end else if (w_oob) begin
            r_if_instr   <= 32'd0;
            r_if_pcplus4 <= 32'd0;
            r_if_valid   <= 1'b0;
          end else begin
            r_if_instr   <= Instruction;
            r_if_pcplus4 <= w_pc_plus4;
            r_if_valid   <= 1'b1;
          end

          // The HALT word itself enters IF/ID as a valid instruction.
          if (w_halt_hit) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end
        end

        ST_HALTED: begin
          // All control inputs ignored; only reset leaves this state.
          r_if_instr   <= 32'd0;
          r_if_pcplus4 <= 32'd0;
          r_if_valid   <= 1'b0;
          r_halted     <= 1'b1;
        end

        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

  assign Address           = r_pc;
  assign PC                = r_pc;
  assign IF_ID_Instruction = r_if_instr;
  assign IF_ID_PCPlus4     = r_if_pcplus4;
  assign IF_ID_Valid       = r_if_valid;
  assign Halted            = r_halted;
  assign DbgState          = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit (default build, bound check disabled).
// A behavioural instruction memory answers Address combinationally; words
// not explicitly programmed hold 32'h1000_0000 + word_index, and addresses
// beyond the modelled 256 words return 32'hDEAD_BEEF. Inputs change 1 time
// unit after a rising edge; outputs are checked at the same point.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        Clk;
  logic        Rst;
  logic        Stall;
  logic        Flush;
  logic        Branch;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic        Halted;
  logic        FetchFault;
  logic [1:0]  DbgState;

  int n_cmp;
  int n_bad;

  logic [31:0] mem [0:255];

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .MEM_WORDS (174),
    .HALT_WORD (32'hFFFF_FFFF)
  ) dut (
    .Clk               (Clk),
    .Rst               (Rst),
    .Stall             (Stall),
    .Flush             (Flush),
    .Branch            (Branch),
    .BranchTarget      (BranchTarget),
    .Jump              (Jump),
    .JumpTarget        (JumpTarget),
    .Address           (Address),
    .Instruction       (Instruction),
    .PC                (PC),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_PCPlus4     (IF_ID_PCPlus4),
    .IF_ID_Valid       (IF_ID_Valid),
    .Halted            (Halted),
    .FetchFault        (FetchFault),
    .DbgState          (DbgState)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Combinational instruction memory model
  assign Instruction = (Address < 32'd1024) ? mem[Address[9:2]] : 32'hDEAD_BEEF;

  // Checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic fl, input logic br,
                       input logic [31:0] bt, input logic jp, input logic [31:0] jt);
    Stall        = st;
    Flush        = fl;
    Branch       = br;
    BranchTarget = bt;
    Jump         = jp;
    JumpTarget   = jt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins,
                          input logic [31:0] p4, input logic [31:0] pc);
    chk({tag, "_ins"},   IF_ID_Instruction, ins);
    chk({tag, "_p4"},    IF_ID_PCPlus4, p4);
    chk({tag, "_valid"}, {31'd0, IF_ID_Valid}, 32'd1);
    chk({tag, "_pc"},    PC, pc);
  endtask

  task automatic chk_bubble(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, IF_ID_Valid}, 32'd0);
    chk({tag, "_ins"},   IF_ID_Instruction, 32'd0);
    chk({tag, "_pc"},    PC, pc);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;

    Rst = 1'b0;
    idle();
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_pc",    PC, 32'd0);
    chk("rst_addr",  Address, 32'd0);
    chk("rst_valid", {31'd0, IF_ID_Valid}, 32'd0);
    chk("rst_ins",   IF_ID_Instruction, 32'd0);
    chk("rst_p4",    IF_ID_PCPlus4, 32'd0);
    chk("rst_halt",  {31'd0, Halted}, 32'd0);
    chk("rst_fault", {31'd0, FetchFault}, 32'd0);
    chk("rst_state", {30'd0, DbgState}, 32'd0);

    // Reset release: BOOT bubble, then sequential fetch
    Rst = 1'b1;
    step();
    chk_bubble("boot", 32'd0);
    chk("boot_state", {30'd0, DbgState}, 32'd1);
    step();
    chk_ifid("fetch0", 32'h2008_0001, 32'd4, 32'd4);
    step();
    chk_ifid("fetch1", 32'h2009_0002, 32'd8, 32'd8);

    // Stall for three cycles at PC=8
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_ifid("stall", 32'h2009_0002, 32'd8, 32'd8);
    end
    idle();
    step();
    chk_ifid("unstall", 32'h1000_0002, 32'd12, 32'd12);
    step();
    chk_ifid("fetch3", 32'h1000_0003, 32'd16, 32'h10);

    // Branch with Stall at PC=0x10, misaligned target
    drive(1'b1, 1'b0, 1'b1, 32'h43, 1'b0, 32'd0);
    step();
    chk_bubble("branch_stall", 32'h40);
    idle();
    step();
    chk_ifid("after_branch", 32'h1000_0010, 32'h44, 32'h44);

    // Jump and Branch together: Jump wins
    drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80);
    step();
    chk_bubble("jump_vs_branch", 32'h80);
    idle();
    step();
    chk_ifid("after_jump", 32'h1000_0020, 32'h84, 32'h84);

    // Flush + Stall without redirect: PC holds, bubble
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    step();
    chk_bubble("flush_stall", 32'h84);
    // Flush alone: PC advances, bubble
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    step();
    chk_bubble("flush", 32'h88);
    idle();
    step();
    chk_ifid("after_flush", 32'h1000_0022, 32'h8C, 32'h8C);

    // Misaligned jump target 0x7 -> 0x4
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h7);
    step();
    chk_bubble("jump_mis", 32'h4);
    idle();
    step();
    chk_ifid("after_jump_mis", 32'h2009_0002, 32'h8, 32'h8);

    // PC+4 wrap at the top of the address space
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
    step();
    chk_bubble("jump_top", 32'hFFFF_FFFC);
    idle();
    step();
    chk_ifid("wrap", 32'hDEAD_BEEF, 32'd0, 32'd0);
    step();
    chk_ifid("post_wrap", 32'h2008_0001, 32'd4, 32'd4);
    chk("fault_off", {31'd0, FetchFault}, 32'd0);

    // Asynchronous reset mid-operation, away from any clock edge
    mem[3] = 32'hFFFF_FFFF;
    #2;
    Rst = 1'b0;
    #1;
    chk("async_pc",    PC, 32'd0);
    chk("async_valid", {31'd0, IF_ID_Valid}, 32'd0);
    chk("async_ins",   IF_ID_Instruction, 32'd0);
    chk("async_state", {30'd0, DbgState}, 32'd0);
    step();
    Rst = 1'b1;

    // Halt word at 0x0C
    step();
    chk_bubble("boot2", 32'd0);
    step();
    step();
    step();
    chk_ifid("pre_halt", 32'h1000_0002, 32'd12, 32'd12);
    chk("pre_halt_flag", {31'd0, Halted}, 32'd0);
    step();
    chk_ifid("halt", 32'hFFFF_FFFF, 32'd16, 32'd12);
    chk("halt_flag",  {31'd0, Halted}, 32'd1);
    chk("halt_state", {30'd0, DbgState}, 32'd2);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0);
    step();
    chk_bubble("halt_jump", 32'd12);
    chk("halt_flag2", {31'd0, Halted}, 32'd1);
    drive(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'd0);
    step();
    chk_bubble("halt_branch", 32'd12);
    idle();
    #2;
    Rst = 1'b0;
    #1;
    chk("unhalt_pc",   PC, 32'd0);
    chk("unhalt_flag", {31'd0, Halted}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
